// File: rtl/mem_seq_master_if.sv
// -----------------------------------------------------------------------------
// mem_seq_master_if
//   Valid/ready single-port memory bus between a request initiator (master)
//   and a memory (slave). The master holds valid, wr_rd, addr and wdata
//   stable until the slave raises ready. A beat completes on a clk edge with
//   valid && ready. On a read beat the slave supplies rdata on that edge.
//
//   Signals:
//     valid  master->slave  request valid
//     wr_rd  master->slave  1 = write, 0 = read
//     addr   master->slave  word address (N bits)
//     wdata  master->slave  write data (W bits)
//     ready  slave->master  beat completion
//     rdata  slave->master  read data, valid on the completing edge of a read
// -----------------------------------------------------------------------------
interface mem_seq_master_if #(
    parameter int W = 4,
    parameter int N = 4
);
    logic         valid;
    logic         wr_rd;
    logic [N-1:0] addr;
    logic [W-1:0] wdata;
    logic         ready;
    logic [W-1:0] rdata;

    modport master (
        output valid, wr_rd, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, wr_rd, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_seq_master.sv
// -----------------------------------------------------------------------------
// mem_seq_master
//   Burst initiator for a valid/ready single-port memory. It accepts one
//   command (op, start address, beat count), walks sequential addresses that
//   wrap modulo D, writes the pattern (D - addr) truncated to W bits, and
//   streams every read back out. For ops 10 and 11 it also compares the read
//   data with the pattern and records the mismatch count and the first
//   failing address.
//
//   Ports:
//     clk, res                 clock, asynchronous active-high reset
//     cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//     cmd_op                   00 write, 01 read, 10 write-then-read,
//                              11 interleaved write/read per address
//     cmd_start, cmd_num       first address, beats per direction
//     mem                      memory bus, master side
//     rd_valid/rd_addr/rd_data one-cycle report of each completed read
//     busy, done               command in progress / end-of-command pulse
//     err_cnt, first_err_addr  read-check results for the current command
// -----------------------------------------------------------------------------
module mem_seq_master #(
    parameter  int W = 4,
    parameter  int D = 16,
    localparam int N = $clog2(D)
) (
    input  logic             clk,
    input  logic             res,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [N-1:0]     cmd_start,
    input  logic [N:0]       cmd_num,

    mem_seq_master_if.master mem,

    output logic             rd_valid,
    output logic [N-1:0]     rd_addr,
    output logic [W-1:0]     rd_data,
    output logic             busy,
    output logic             done,
    output logic [N:0]       err_cnt,
    output logic [N-1:0]     first_err_addr
);

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_WR_RD = 2'b10;
    localparam logic [1:0] OP_IL    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        FIN
    } state_t;

    state_t       state;
    logic [1:0]   op_r;
    logic [N-1:0] start_r;
    logic [N:0]   num_r;
    logic [N:0]   cnt;        // beats (or write/read pairs) finished in this pass
    logic [N:0]   cnt_inc;
    logic [N-1:0] addr_nxt;

    // Deterministic write pattern; also the reference for read checking.
    function automatic logic [W-1:0] pattern(input logic [N-1:0] a);
        return W'(D - int'(a));
    endfunction

    // Sequential address with wrap at D-1 (D need not be a power of two).
    function automatic logic [N-1:0] next_addr(input logic [N-1:0] a);
        return (int'(a) == D - 1) ? '0 : a + 1'b1;
    endfunction

    assign cnt_inc   = cnt + 1'b1;
    assign addr_nxt  = next_addr(mem.addr);
    assign cmd_ready = (state == IDLE) && !res;

    // NOTE: every register here is assigned with <= so all of them update
    // together from pre-edge values; a blocking '=' would let later lines see
    // half-updated state and break the one-cycle handshake timing.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state          <= IDLE;
            op_r           <= OP_WR;
            start_r        <= '0;
            num_r          <= '0;
            cnt            <= '0;
            mem.valid      <= 1'b0;
            mem.wr_rd      <= 1'b0;
            mem.addr       <= '0;
            mem.wdata      <= '0;
            rd_valid       <= 1'b0;
            rd_addr        <= '0;
            rd_data        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r           <= cmd_op;
                        start_r        <= cmd_start;
                        num_r          <= cmd_num;
                        cnt            <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        busy           <= 1'b1;
                        mem.addr       <= cmd_start;
                        mem.wdata      <= pattern(cmd_start);
                        if (cmd_num == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (cmd_op == OP_RD) begin
                            state     <= RD;
                            mem.valid <= 1'b1;
                            mem.wr_rd <= 1'b0;
                        end else begin
                            state     <= WR;
                            mem.valid <= 1'b1;
                            mem.wr_rd <= 1'b1;
                        end
                    end
                end

                // valid is always high in WR/RD, so ready alone marks completion.
                WR: begin
                    if (mem.ready) begin
                        if (op_r == OP_IL) begin
                            // Read back the address just written.
                            state     <= RD;
                            mem.wr_rd <= 1'b0;
                        end else if (cnt_inc == num_r) begin
                            if (op_r == OP_WR_RD) begin
                                state     <= RD;
                                mem.wr_rd <= 1'b0;
                                cnt       <= '0;
                                mem.addr  <= start_r;
                                mem.wdata <= pattern(start_r);
                            end else begin
                                state     <= FIN;
                                mem.valid <= 1'b0;
                                done      <= 1'b1;
                            end
                        end else begin
                            cnt       <= cnt_inc;
                            mem.addr  <= addr_nxt;
                            mem.wdata <= pattern(addr_nxt);
                        end
                    end
                end

                RD: begin
                    if (mem.ready) begin
                        rd_valid <= 1'b1;
                        rd_addr  <= mem.addr;
                        rd_data  <= mem.rdata;
                        // op[1] set means the data is expected to be our pattern.
                        if (op_r[1] && (mem.rdata != pattern(mem.addr))) begin
                            if (err_cnt == '0) begin
                                first_err_addr <= mem.addr;
                            end
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        if (cnt_inc == num_r) begin
                            state     <= FIN;
                            mem.valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt       <= cnt_inc;
                            mem.addr  <= addr_nxt;
                            mem.wdata <= pattern(addr_nxt);
                            if (op_r == OP_IL) begin
                                state     <= WR;
                                mem.wr_rd <= 1'b1;
                            end
                        end
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    mem.valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq_master.sv
// -----------------------------------------------------------------------------
// tb_mem_seq_master
//   Drives commands into mem_seq_master, models the memory with randomised
//   ready timing, and compares the beat stream, read reports and check
//   results against a reference built from address arithmetic and a shadow
//   memory image.
// -----------------------------------------------------------------------------
module tb_mem_seq_master;

    localparam int W = 4;
    localparam int D = 16;
    localparam int N = $clog2(D);

    logic         clk = 1'b0;
    logic         res;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_start;
    logic [N:0]   cmd_num;
    logic         rd_valid;
    logic [N-1:0] rd_addr;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         done;
    logic [N:0]   err_cnt;
    logic [N-1:0] first_err_addr;

    mem_seq_master_if #(.W(W), .N(N)) mem_bus ();

    mem_seq_master #(.W(W), .D(D)) dut (
        .clk            (clk),
        .res            (res),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_start      (cmd_start),
        .cmd_num        (cmd_num),
        .mem            (mem_bus),
        .rd_valid       (rd_valid),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit wr; int a; int d; } beat_t;
    typedef struct { int a; int d; } rd_t;

    beat_t exp_beats[$];
    rd_t   exp_reads[$];
    int    ref_mem[D];
    int    exp_err, exp_first, exp_total;

    // Memory-model controls (written by the stimulus, read by the responder).
    int ready_mode   = 0;   // 0: always ready, 1: random, 2: two waits per beat
    bit corrupt_en   = 0;
    int corrupt_addr = 0;

    function automatic int pat(int a);
        return (D - a) % (1 << W);
    endfunction

    function automatic int init_val(int i);
        return (i * 7 + 3) % (1 << W);
    endfunction

    task automatic model_read(input int a, input bit chk);
        int d;
        d = (corrupt_en && a == corrupt_addr) ? 0 : ref_mem[a];
        exp_beats.push_back('{wr: 1'b0, a: a, d: 0});
        exp_reads.push_back('{a: a, d: d});
        if (chk && d != pat(a)) begin
            if (exp_err == 0) exp_first = a;
            if (exp_err < (1 << (N + 1)) - 1) exp_err++;
        end
    endtask

    task automatic model_write(input int a);
        exp_beats.push_back('{wr: 1'b1, a: a, d: pat(a)});
        ref_mem[a] = pat(a);
    endtask

    task automatic build_expect(input int op, input int start, input int num);
        exp_beats.delete();
        exp_reads.delete();
        exp_err   = 0;
        exp_first = 0;
        exp_total = (op >= 2) ? 2 * num : num;
        case (op)
            0: for (int k = 0; k < num; k++) model_write((start + k) % D);
            1: for (int k = 0; k < num; k++) model_read((start + k) % D, 1'b0);
            2: begin
                for (int k = 0; k < num; k++) model_write((start + k) % D);
                for (int k = 0; k < num; k++) model_read((start + k) % D, 1'b1);
            end
            default: for (int k = 0; k < num; k++) begin
                model_write((start + k) % D);
                model_read((start + k) % D, 1'b1);
            end
        endcase
    endtask

    // ---------------- memory responder + monitor ----------------
    logic [W-1:0] mem_arr [D];
    bit           mem_loaded = 0;
    bit           stalled    = 0;
    int           wait_cnt   = 0;
    logic         prev_wr;
    logic [N-1:0] prev_addr;
    logic [W-1:0] prev_wdata;

    always @(negedge clk) begin
        bit rdy;
        if (!mem_loaded) begin
            for (int i = 0; i < D; i++) mem_arr[i] = W'(init_val(i));
            mem_loaded = 1;
        end
        if (res) begin
            stalled = 0;
            wait_cnt = 0;
            mem_bus.ready = 1'b0;
            mem_bus.rdata = '0;
        end else begin
            if (stalled) begin
                check("hold_valid", mem_bus.valid, 1);
                check("hold_wr_rd", mem_bus.wr_rd, prev_wr);
                check("hold_addr",  mem_bus.addr,  prev_addr);
                check("hold_wdata", mem_bus.wdata, prev_wdata);
            end
            case (ready_mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    if (mem_bus.valid && wait_cnt == 2) begin
                        rdy = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        rdy = 1'b0;
                        if (mem_bus.valid) wait_cnt++;
                    end
                end
            endcase
            mem_bus.ready = rdy;
            mem_bus.rdata = (corrupt_en && int'(mem_bus.addr) == corrupt_addr) ? '0
                            : mem_arr[mem_bus.addr];

            if (mem_bus.valid && rdy) begin
                if (exp_beats.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_dir",  mem_bus.wr_rd, b.wr);
                    check("beat_addr", mem_bus.addr,  b.a);
                    if (b.wr) check("beat_wdata", mem_bus.wdata, b.d);
                end
                if (mem_bus.wr_rd) mem_arr[mem_bus.addr] = mem_bus.wdata;
            end
            stalled    = mem_bus.valid && !rdy;
            prev_wr    = mem_bus.wr_rd;
            prev_addr  = mem_bus.addr;
            prev_wdata = mem_bus.wdata;

            if (rd_valid) begin
                if (exp_reads.size() == 0) begin
                    check("extra_rd_valid", 1, 0);
                end else begin
                    rd_t r;
                    r = exp_reads.pop_front();
                    check("rd_addr", rd_addr, r.a);
                    check("rd_data", rd_data, r.d);
                end
            end
            check("cmd_ready_vs_busy", cmd_ready, !busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_cmd(input int op, input int start, input int num);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_start = N'(start);
        cmd_num   = (N + 1)'(num);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int op, input int start, input int num);
        int n;
        bit seen;
        build_expect(op, start, num);
        drive_cmd(op, start, num);
        seen = 0;
        for (n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            // Commands offered while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_start = N'($urandom);
            cmd_num   = (N + 1)'($urandom);
        end
        cmd_valid = 1'b0;
        check("done_seen", seen, 1);
        if (seen) begin
            check("busy_with_done", busy, 1);
            check("no_valid_at_done", mem_bus.valid, 0);
            if (ready_mode == 0) check("done_latency", n, exp_total + 1);
        end
        #1;
        check("beats_left", exp_beats.size(), 0);
        check("reads_left", exp_reads.size(), 0);
        check("err_cnt", err_cnt, exp_err);
        check("first_err_addr", first_err_addr, exp_first);
        @(negedge clk);
        #1;
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("cmd_ready_after", cmd_ready, 1);
        exp_beats.delete();
        exp_reads.delete();
    endtask

    task automatic reset_check(input string tag);
        res = 1'b1;
        #1;
        check({tag, "_valid"},     mem_bus.valid, 0);
        check({tag, "_wr_rd"},     mem_bus.wr_rd, 0);
        check({tag, "_addr"},      mem_bus.addr, 0);
        check({tag, "_wdata"},     mem_bus.wdata, 0);
        check({tag, "_rd_valid"},  rd_valid, 0);
        check({tag, "_rd_addr"},   rd_addr, 0);
        check({tag, "_rd_data"},   rd_data, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_err_cnt"},   err_cnt, 0);
        check({tag, "_first_err"}, first_err_addr, 0);
        @(negedge clk);
        res = 1'b0;
        #1;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int exp4[4] = '{0, 15, 14, 13};
        int snap[D];

        res       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_start = '0;
        cmd_num   = '0;
        for (int i = 0; i < D; i++) ref_mem[i] = init_val(i);
        repeat (2) @(negedge clk);
        reset_check("por");

        // Write-only, fast memory.
        ready_mode = 0;
        run_cmd(0, 0, 4);
        for (int i = 0; i < 4; i++) check("wr_mem_image", mem_arr[i], exp4[i]);

        // Write-then-read with two wait cycles per beat.
        ready_mode = 2;
        run_cmd(2, 2, 3);

        // Fault detect: address 2 reads back as 0.
        ready_mode   = 0;
        corrupt_en   = 1;
        corrupt_addr = 2;
        run_cmd(2, 0, 4);
        check("fault_err_cnt", err_cnt, 1);
        check("fault_first_addr", first_err_addr, 2);
        corrupt_en = 0;

        // Reset while idle clears the held results.
        @(negedge clk);
        reset_check("idle_rst");

        // Wrap and interleave.
        run_cmd(3, 14, 4);

        // Zero-length command.
        run_cmd(1, 5, 0);

        // Reset during the second beat of an 8-beat write.
        snap = ref_mem;
        build_expect(0, 0, 8);
        drive_cmd(0, 0, 8);
        @(posedge clk);
        #2;
        reset_check("mid_rst");
        ref_mem    = snap;
        ref_mem[0] = pat(0);
        exp_beats.delete();
        exp_reads.delete();
        check("mid_rst_mem0", mem_arr[0], pat(0));
        check("mid_rst_mem1", mem_arr[1], snap[1]);

        // Clean restart after reset.
        run_cmd(2, 5, 6);

        // Randomised commands with random ready timing and optional corruption.
        ready_mode = 1;
        for (int t = 0; t < 14; t++) begin
            corrupt_en   = 1'($urandom_range(0, 1));
            corrupt_addr = $urandom_range(0, D - 1);
            run_cmd($urandom_range(0, 3), $urandom_range(0, D - 1), $urandom_range(0, 2 * D - 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
